// File: rtl/jtpopeye_rom_arb.sv
// Shares one SDRAM read port between three ROM slots (main CPU, char, object).
// Each slot keeps a one-entry cache; misses are served in round-robin order.
module jtpopeye_rom_arb #(
    parameter int unsigned   AW      = 22,
    parameter logic [AW-1:0] OFF0    = 22'h00000,
    parameter logic [AW-1:0] OFF1    = 22'h08000,
    parameter logic [AW-1:0] OFF2    = 22'h0C000,
    parameter int unsigned   TIMEOUT = 63
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,
    input  logic          loop_rst,
    input  logic          slot0_cs,
    input  logic [AW-1:0] slot0_addr,
    output logic [31:0]   slot0_dout,
    output logic          slot0_ok,
    input  logic          slot1_cs,
    input  logic [AW-1:0] slot1_addr,
    output logic [31:0]   slot1_dout,
    output logic          slot1_ok,
    input  logic          slot2_cs,
    input  logic [AW-1:0] slot2_addr,
    output logic [31:0]   slot2_dout,
    output logic          slot2_ok,
    output logic [AW-1:0] sdram_addr,
    output logic          sdram_re,
    input  logic [31:0]   data_read,
    input  logic          data_rdy
);

    localparam int unsigned     CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [AW-1:0]       req_addr_q, req_addr_d;
    logic [AW-1:0]       sdram_addr_q, sdram_addr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                re_q, re_d;
    logic [2:0]          valid_q;
    logic [2:0][AW-1:0]  tag_q;
    logic [2:0][31:0]    data_q;

    logic [2:0]          cs, hit, pending, ok;
    logic [2:0][AW-1:0]  addr, offs;
    logic [1:0]          ord1, ord2, sel;
    logic                fill, flush;

    function automatic logic [1:0] next_slot(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    assign cs   = {slot2_cs, slot1_cs, slot0_cs};
    assign addr = {slot2_addr, slot1_addr, slot0_addr};
    assign offs = {OFF2, OFF1, OFF0};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            hit[i] = valid_q[i] && (tag_q[i] == addr[i]);
        end
    end

    assign pending = cs & ~hit;
    assign ok      = cs & hit & {3{~downloading}};

    // Priority order starts at the round-robin pointer and wraps mod 3
    assign ord1 = next_slot(ptr_q);
    assign ord2 = next_slot(ord1);

    always_comb begin
        if (pending[ptr_q]) begin
            sel = ptr_q;
        end else if (pending[ord1]) begin
            sel = ord1;
        end else begin
            sel = ord2;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        req_addr_d   = req_addr_q;
        sdram_addr_d = sdram_addr_q;
        cnt_d        = cnt_q;
        re_d         = 1'b0;
        fill         = 1'b0;
        flush        = 1'b0;
        if (downloading || loop_rst) begin
            // Drop any outstanding fetch; its data_rdy will land in IDLE and be ignored
            state_d = StIdle;
            flush   = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|pending) begin
                        gnt_d        = sel;
                        req_addr_d   = addr[sel];
                        sdram_addr_d = offs[sel] + addr[sel];
                        re_d         = 1'b1;
                        cnt_d        = '0;
                        state_d      = StWait;
                    end
                end
                StWait: begin
                    if (data_rdy) begin
                        fill    = 1'b1;
                        ptr_d   = next_slot(gnt_q);
                        state_d = StIdle;
                    end else if (cnt_q == CntMax) begin
                        re_d  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= 2'd0;
            gnt_q        <= 2'd0;
            req_addr_q   <= '0;
            sdram_addr_q <= '0;
            cnt_q        <= '0;
            re_q         <= 1'b0;
            valid_q      <= '0;
            tag_q        <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            req_addr_q   <= req_addr_d;
            sdram_addr_q <= sdram_addr_d;
            cnt_q        <= cnt_d;
            re_q         <= re_d;
            if (flush) begin
                valid_q <= '0;
            end else if (fill) begin
                valid_q[gnt_q] <= 1'b1;
                tag_q[gnt_q]   <= req_addr_q;
                data_q[gnt_q]  <= data_read;
            end
        end
    end

    assign slot0_ok   = ok[0];
    assign slot1_ok   = ok[1];
    assign slot2_ok   = ok[2];
    assign slot0_dout = data_q[0];
    assign slot1_dout = data_q[1];
    assign slot2_dout = data_q[2];
    assign sdram_addr = sdram_addr_q;
    assign sdram_re   = re_q;

endmodule
